stream_mux_n: RTL and testbench

- Parametrised N-channel, W-bit selector with valid/ready handshakes on every input and on the single output.
- Two selection modes at runtime:
  - fixed select: an external sel port picks the channel, as in the plain combinational 2:1 mux.
  - round-robin arbitration: the block picks fairly among channels with data.
- One registered output stage gives 1-cycle latency and holds data under backpressure.
- Sits between multiple producers and one consumer in the datapath.

---
 rtl/stream_mux_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/stream_mux_n.sv | 98 +++++++++
 tb/tb_stream_mux_n.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-channel stream selector.
// MODE_FIXED : the external sel port chooses the channel.
// MODE_RR    : round-robin arbitration among channels with valid data.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching from ptr upwards with wrap. The caller owns the pointer register.
// Ports:
//   req       in  N_CH   request vector
//   ptr       in  SEL_W  channel with highest priority this cycle
//   en        in  1      enables arbitration; no grant when low
//   grant     out N_CH   one-hot grant (all zero when nothing granted)
//   grant_idx out SEL_W  index of the granted channel (0 when no grant)
module rr_arbiter #(
    parameter int unsigned N_CH = 4
) (
    input  logic [N_CH-1:0]           req,
    input  logic [$clog2(N_CH)-1:0]   ptr,
    input  logic                      en,
    output logic [N_CH-1:0]           grant,
    output logic [$clog2(N_CH)-1:0]   grant_idx
);

    localparam int unsigned SEL_W = $clog2(N_CH);

    int unsigned      cand;
    logic [SEL_W-1:0] cand_idx;
    logic             found;

    // Walk ptr, ptr+1, ... modulo N_CH and keep only the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand     = (32'(ptr) + k) % N_CH;
            cand_idx = SEL_W'(cand);
            if (en && !found && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel W-bit stream selector with valid/ready on every input and a single
// registered output stage (1-cycle latency, holds data under backpressure).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mode                0 = fixed select via sel, 1 = round-robin
//   sel                 channel index used in fixed mode
//   in_valid/in_data    per-channel valid and packed data (channel i at [i*W +: W])
//   in_ready            per-channel ready (combinational)
//   out_valid/out_data  registered output word
//   out_ch              channel that supplied out_data
//   out_ready           consumer accepts the output
//   sel_err             registered flag: fixed mode with sel >= N_CH
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [N_CH-1:0]     in_valid,
    input  logic [N_CH*W-1:0]   in_data,
    output logic [N_CH-1:0]     in_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    input  logic                out_ready,
    output logic                sel_err
);

    logic [N_CH-1:0]  rr_grant;
    logic [N_CH-1:0]  fix_grant;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W-1:0] ptr;
    logic             sel_bad;
    logic             load;
    logic             xfer;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .en        (mode == MODE_RR),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // sel values past the last channel exist only when N_CH is not a power of 2.
    assign sel_bad = 32'(sel) >= N_CH;

    // Fixed-select grant: only the selected channel may be granted.
    always_comb begin
        fix_grant = '0;
        if (!sel_bad) begin
            fix_grant[sel] = in_valid[sel];
        end
    end

    assign grant    = (mode == MODE_RR) ? rr_grant : fix_grant;
    assign gnt_idx  = (mode == MODE_RR) ? rr_idx   : sel;
    assign load     = ~out_valid | out_ready;
    assign in_ready = grant & {N_CH{load}};
    assign xfer     = |in_ready;

    // Output register, round-robin pointer and select-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
            ptr       <= '0;
        end else begin
            sel_err <= (mode == MODE_FIXED) & sel_bad;
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[32'(gnt_idx)*W +: W];
                out_ch    <= gnt_idx;
                if (mode == MODE_RR) begin
                    if (32'(gnt_idx) == N_CH - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= gnt_idx + SEL_W'(1);
                    end
                end
            end else if (load) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: directed scenarios followed by random
// traffic on a 4-channel instance, compared against a behavioural model;
// a 3-channel instance covers the out-of-range select flag.
module tb_stream_mux_n;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;
    logic        sel_err;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3;
    logic        sel_err3;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       m_valid;
    bit [7:0] m_data;
    int       m_ch;
    int       m_ptr;
    bit       m_err;

    stream_mux_n #(.N_CH(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    stream_mux_n #(.N_CH(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3), .sel_err(sel_err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel the rules would grant this cycle, or -1 for none.
    function automatic int pick(input bit md, input int s, input logic [3:0] v, input int p);
        if (!md) begin
            if (s < 4 && v[2'(s)]) return s;
            return -1;
        end
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (v[2'(c)]) return c;
        end
        return -1;
    endfunction

    // Entered at posedge+1 with inputs already applied; returns at next posedge+1.
    task automatic cycle();
        int         g;
        bit         ld;
        logic [3:0] er;
        g  = pick(mode, int'(sel), in_valid, m_ptr);
        ld = !m_valid || out_ready;
        er = (g >= 0 && ld) ? 4'(1 << g) : 4'b0000;
        #3;
        chk("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        m_err = (mode == 1'b0) && (int'(sel) >= 4);
        if (er != 4'b0000) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_ch    = g;
            if (mode) m_ptr = (g + 1) % 4;
        end else if (ld) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_ch",    32'(out_ch),    32'(m_ch));
        chk("sel_err",   32'(sel_err),   32'(m_err));
    endtask

    initial begin
        rst_n = 1'b0;
        mode = 1'b0; sel = 2'd0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b1;
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; m_err = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_sel_err",   32'(sel_err),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fixed select of ch2; ch0 stays valid but must never be taken.
        in_data = 32'h13_3C_11_77;
        in_valid = 4'b0101; sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("fixed_data", 32'(out_data), 32'h3C);
            chk("fixed_ch",   32'(out_ch),   32'd2);
        end
        in_valid = '0;
        cycle();

        // Round-robin fairness with all channels valid.
        mode = 1'b1;
        in_data = 32'h13_12_11_10; in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_seq_ch",   32'(out_ch),   32'(i % 4));
            chk("rr_seq_data", 32'(out_data), 32'(8'h10 + 8'(i % 4)));
        end
        in_valid = '0;
        cycle();

        // Backpressure after the first word.
        in_valid = 4'b1111;
        cycle();
        chk("bp_first", 32'(out_data), 32'h10);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold", 32'(out_data), 32'h10);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_next_ch", 32'(out_ch), 32'd1);

        // Move ptr to 3, then only ch3 and ch1 valid: wrap past 0.
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'b1010;
        cycle();
        chk("wrap_first", 32'(out_ch), 32'd3);
        cycle();
        chk("wrap_second", 32'(out_ch), 32'd1);
        in_valid = 4'b1111;
        cycle();
        chk("ptr_after_wrap", 32'(out_ch), 32'd2);

        // Asynchronous reset while holding a word.
        mode = 1'b0; sel = 2'd0; in_data = 32'h000000A5; in_valid = 4'b0001;
        cycle();
        out_ready = 1'b0; in_valid = '0;
        cycle();
        chk("hold_a5", 32'(out_data), 32'hA5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data",  32'(out_data),  32'd0);
        chk("arst_ch",    32'(out_ch),    32'd0);
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; m_err = 1'b0;
        #1 rst_n = 1'b1;
        mode = 1'b1; out_ready = 1'b1; in_data = 32'h13_12_11_10; in_valid = 4'b1111;
        cycle();
        chk("ptr_after_rst", 32'(out_ch), 32'd0);
        in_valid = '0;
        cycle();

        // Out-of-range select on the 3-channel instance.
        sel3 = 2'd1; in_valid3 = 3'b111; in_data3 = 24'h22_21_20;
        #1;
        chk("sel3_ready", 32'(in_ready3), 32'b010);
        cycle();
        chk("sel3_valid", 32'(out_valid3), 32'd1);
        chk("sel3_data",  32'(out_data3),  32'h21);
        chk("sel3_err0",  32'(sel_err3),   32'd0);
        sel3 = 2'd3;
        #1;
        chk("bad_ready", 32'(in_ready3), 32'd0);
        cycle();
        chk("bad_drain",  32'(out_valid3), 32'd0);
        chk("bad_err",    32'(sel_err3),   32'd1);
        chk("bad_keep",   32'(out_data3),  32'h21);
        mode3 = 1'b1;
        cycle();
        chk("rr_err_clr", 32'(sel_err3),   32'd0);
        chk("rr3_ch",     32'(out_ch3),    32'd0);
        chk("rr3_data",   32'(out_data3),  32'h20);
        in_valid3 = '0;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
